// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard bundle between the pipeline datapath and the stall/flush controller.
// master: datapath (drives hazard sources, reads stall/flush); slave: controller.
interface pipe_hazard_ctrl_if;
  logic [4:0] i_id_rs1;
  logic [4:0] i_id_rs2;
  logic       i_id_rs1_used;
  logic       i_id_rs2_used;
  logic       i_ex_valid;
  logic       i_ex_mem_read;
  logic [4:0] i_ex_rd;
  logic       i_ex_mispred;
  logic       i_mem_req;
  logic       i_mem_ack;
  logic       o_pc_stall;
  logic       o_if_id_stall;
  logic       o_id_ex_stall;
  logic       o_ex_mem_stall;
  logic       o_mem_wb_stall;
  logic       o_if_id_flush;
  logic       o_id_ex_flush;
  logic       o_ex_mem_flush;
  logic       o_mem_wb_flush;

  modport master (
    output i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
    output i_ex_valid, i_ex_mem_read, i_ex_rd, i_ex_mispred,
    output i_mem_req, i_mem_ack,
    input  o_pc_stall, o_if_id_stall, o_id_ex_stall,
    input  o_ex_mem_stall, o_mem_wb_stall,
    input  o_if_id_flush, o_id_ex_flush,
    input  o_ex_mem_flush, o_mem_wb_flush
  );

  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
    input  i_ex_valid, i_ex_mem_read, i_ex_rd, i_ex_mispred,
    input  i_mem_req, i_mem_ack,
    output o_pc_stall, o_if_id_stall, o_id_ex_stall,
    output o_ex_mem_stall, o_mem_wb_stall,
    output o_if_id_flush, o_id_ex_flush,
    output o_ex_mem_flush, o_mem_wb_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use bubble, mispredict squash, dmem wait
// with timeout watchdog. Ports: i_clk, i_reset (async high), hz (slave bundle),
// o_state, o_mem_timeout, o_stall_cycles, o_flush_events.
// Define PIPE_HAZARD_CTRL_PERF_EN to build the saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  pipe_hazard_ctrl_if.slave  hz,
  output logic [1:0]         o_state,
  output logic               o_mem_timeout,
  output logic [31:0]        o_stall_cycles,
  output logic [31:0]        o_flush_events
);

  typedef enum logic [1:0] {
    S_RUN      = 2'b00,
    S_MEM_WAIT = 2'b01,
    S_TIMEOUT  = 2'b10
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_wait_cnt;
  logic       r_mem_timeout;

  logic w_lu;
  logic w_mw;
  logic w_pc_stall;
  logic w_if_id_stall;
  logic w_id_ex_stall;
  logic w_ex_mem_stall;
  logic w_mem_wb_stall;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_mem_wb_flush;
  logic w_flush_evt;

  assign w_lu = hz.i_ex_valid & hz.i_ex_mem_read
              & (hz.i_ex_rd != 5'd0)
              & ((hz.i_id_rs1_used & (hz.i_id_rs1 == hz.i_ex_rd))
               | (hz.i_id_rs2_used & (hz.i_id_rs2 == hz.i_ex_rd)));

  assign w_mw = hz.i_mem_req & ~hz.i_mem_ack;

  always_comb begin
    w_pc_stall     = 1'b0;
    w_if_id_stall  = 1'b0;
    w_id_ex_stall  = 1'b0;
    w_ex_mem_stall = 1'b0;
    w_mem_wb_stall = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_mem_wb_flush = 1'b0;
    w_flush_evt    = 1'b0;
    if (!i_reset) begin
      unique case (r_state)
        S_RUN: begin
          if (w_mw) begin
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_ex_stall  = 1'b1;
            w_ex_mem_stall = 1'b1;
            w_mem_wb_flush = 1'b1;
          end else if (hz.i_ex_mispred) begin
            // ID holds a wrong-path instruction, so any load-use is moot
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            w_flush_evt   = 1'b1;
          end else if (w_lu) begin
            w_pc_stall    = 1'b1;
            w_if_id_stall = 1'b1;
            w_id_ex_flush = 1'b1;
          end
        end
        S_MEM_WAIT: begin
          // ack cycle releases everything so MEM/WB captures the data
          if (!hz.i_mem_ack) begin
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_ex_stall  = 1'b1;
            w_ex_mem_stall = 1'b1;
            w_mem_wb_flush = 1'b1;
          end
        end
        S_TIMEOUT: begin
          w_pc_stall     = 1'b1;
          w_if_id_stall  = 1'b1;
          w_id_ex_stall  = 1'b1;
          w_ex_mem_stall = 1'b1;
          w_mem_wb_stall = 1'b1;
        end
        default: begin
          w_pc_stall = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_RUN;
      r_wait_cnt    <= 8'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (w_mw) begin
            r_state    <= S_MEM_WAIT;
            r_wait_cnt <= 8'd0;
          end
        end
        S_MEM_WAIT: begin
          if (hz.i_mem_ack) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 8'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
            if (r_wait_cnt == LP_LAST) begin
              r_state       <= S_TIMEOUT;
              r_mem_timeout <= 1'b1;
            end
          end
        end
        S_TIMEOUT: begin
          r_state <= S_TIMEOUT;
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_cycles <= 32'd0;
      r_flush_events <= 32'd0;
    end else begin
      if (w_pc_stall && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_flush_evt && (r_flush_events != 32'hFFFF_FFFF))
        r_flush_events <= r_flush_events + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_events = r_flush_events;
`else
  assign o_stall_cycles = 32'h0;
  assign o_flush_events = 32'h0;
`endif

  assign hz.o_pc_stall     = w_pc_stall;
  assign hz.o_if_id_stall  = w_if_id_stall;
  assign hz.o_id_ex_stall  = w_id_ex_stall;
  assign hz.o_ex_mem_stall = w_ex_mem_stall;
  assign hz.o_mem_wb_stall = w_mem_wb_stall;
  assign hz.o_if_id_flush  = w_if_id_flush;
  assign hz.o_id_ex_flush  = w_id_ex_flush;
  assign hz.o_ex_mem_flush = 1'b0;
  assign hz.o_mem_wb_flush = w_mem_wb_flush;

  assign o_state       = r_state;
  assign o_mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4.
// Stall/flush vector order: pc,ifid,idex,exmem,memwb stall | ifid,idex,exmem,memwb flush.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [8:0] V_NONE   = 9'b00000_0000;
  localparam logic [8:0] V_FREEZE = 9'b11110_0001;
  localparam logic [8:0] V_LU     = 9'b11000_0100;
  localparam logic [8:0] V_MISP   = 9'b00000_1100;
  localparam logic [8:0] V_HALT   = 9'b11111_0000;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [1:0]  o_state;
  logic        o_mem_timeout;
  logic [31:0] o_stall_cycles;
  logic [31:0] o_flush_events;
  logic [8:0]  w_out;
  int          n_checks = 0;
  int          n_fail = 0;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .hz             (hz),
    .o_state        (o_state),
    .o_mem_timeout  (o_mem_timeout),
    .o_stall_cycles (o_stall_cycles),
    .o_flush_events (o_flush_events)
  );

  always #5 i_clk = ~i_clk;

  assign w_out = {hz.o_pc_stall, hz.o_if_id_stall, hz.o_id_ex_stall,
                  hz.o_ex_mem_stall, hz.o_mem_wb_stall,
                  hz.o_if_id_flush, hz.o_id_ex_flush,
                  hz.o_ex_mem_flush, hz.o_mem_wb_flush};

  task automatic clr_inputs();
    hz.i_id_rs1 = 5'd0; hz.i_id_rs2 = 5'd0;
    hz.i_id_rs1_used = 1'b0; hz.i_id_rs2_used = 1'b0;
    hz.i_ex_valid = 1'b0; hz.i_ex_mem_read = 1'b0;
    hz.i_ex_rd = 5'd0; hz.i_ex_mispred = 1'b0;
    hz.i_mem_req = 1'b0; hz.i_mem_ack = 1'b0;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    clr_inputs();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1,
                        input logic u1, input logic [4:0] rs2, input logic u2);
    hz.i_ex_valid = 1'b1; hz.i_ex_mem_read = 1'b1; hz.i_ex_rd = rd;
    hz.i_id_rs1 = rs1; hz.i_id_rs1_used = u1;
    hz.i_id_rs2 = rs2; hz.i_id_rs2_used = u2;
  endtask

  task automatic test_reset();
    clr_inputs();
    hz.i_mem_req = 1'b1;
    i_reset = 1'b1;
    #3;
    n_checks++; if (w_out !== V_NONE) begin n_fail++; $display("FAIL rst_forced out=%b exp=%b", w_out, V_NONE); end
    step();
    i_reset = 1'b0;
    hz.i_mem_req = 1'b0;
    #1;
    n_checks++; if (w_out !== V_NONE) begin n_fail++; $display("FAIL idle_out out=%b exp=%b", w_out, V_NONE); end
    n_checks++; if (o_state !== 2'b00) begin n_fail++; $display("FAIL idle_state got=%b exp=00", o_state); end
    n_checks++; if (o_mem_timeout !== 1'b0) begin n_fail++; $display("FAIL idle_tmo got=%b exp=0", o_mem_timeout); end
    n_checks++; if (o_stall_cycles !== 32'd0 || o_flush_events !== 32'd0) begin n_fail++; $display("FAIL idle_ctr stall=%0d flush=%0d exp=0", o_stall_cycles, o_flush_events); end
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu(5'd5, 5'd1, 1'b1, 5'd5, 1'b1);
    #1;
    n_checks++; if (w_out !== V_LU) begin n_fail++; $display("FAIL lu_rs2 out=%b exp=%b", w_out, V_LU); end
    step();
    hz.i_ex_mem_read = 1'b0; hz.i_ex_rd = 5'd9;
    #1;
    n_checks++; if (w_out !== V_NONE) begin n_fail++; $display("FAIL lu_bubble_done out=%b exp=%b", w_out, V_NONE); end
    n_checks++; if (o_stall_cycles !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL lu_stall_ctr got=%0d exp=%0d", o_stall_cycles, PERF ? 1 : 0); end
    set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    n_checks++; if (w_out !== V_NONE) begin n_fail++; $display("FAIL lu_rd0 out=%b exp=%b", w_out, V_NONE); end
    set_lu(5'd5, 5'd1, 1'b1, 5'd5, 1'b0);
    #1;
    n_checks++; if (w_out !== V_NONE) begin n_fail++; $display("FAIL lu_unused out=%b exp=%b", w_out, V_NONE); end
    set_lu(5'd17, 5'd17, 1'b1, 5'd3, 1'b0);
    #1;
    n_checks++; if (w_out !== V_LU) begin n_fail++; $display("FAIL lu_rs1 out=%b exp=%b", w_out, V_LU); end
    hz.i_ex_valid = 1'b0;
    #1;
    n_checks++; if (w_out !== V_NONE) begin n_fail++; $display("FAIL lu_exinv out=%b exp=%b", w_out, V_NONE); end
    step();
  endtask

  task automatic test_mispred();
    do_reset();
    set_lu(5'd5, 5'd1, 1'b1, 5'd5, 1'b1);
    hz.i_ex_mispred = 1'b1;
    #1;
    n_checks++; if (w_out !== V_MISP) begin n_fail++; $display("FAIL misp_lu out=%b exp=%b", w_out, V_MISP); end
    step();
    clr_inputs();
    #1;
    n_checks++; if (o_flush_events !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL misp_ctr got=%0d exp=%0d", o_flush_events, PERF ? 1 : 0); end
    n_checks++; if (o_stall_cycles !== 32'd0) begin n_fail++; $display("FAIL misp_no_stall got=%0d exp=0", o_stall_cycles); end
    step();
  endtask

  task automatic test_mem_wait();
    do_reset();
    hz.i_mem_req = 1'b1; hz.i_mem_ack = 1'b1;
    #1;
    n_checks++; if (w_out !== V_NONE) begin n_fail++; $display("FAIL mw_zero_wait out=%b exp=%b", w_out, V_NONE); end
    step();
    n_checks++; if (o_state !== 2'b00) begin n_fail++; $display("FAIL mw_zero_state got=%b exp=00", o_state); end
    hz.i_mem_ack = 1'b0;
    #1;
    n_checks++; if (w_out !== V_FREEZE) begin n_fail++; $display("FAIL mw_req out=%b exp=%b", w_out, V_FREEZE); end
    step();
    for (int i = 0; i < 2; i++) begin
      hz.i_ex_mispred = (i == 1);
      set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      #1;
      n_checks++; if (w_out !== V_FREEZE || o_state !== 2'b01) begin n_fail++; $display("FAIL mw_wait%0d out=%b st=%b exp=%b st=01", i, w_out, o_state, V_FREEZE); end
      step();
    end
    clr_inputs();
    hz.i_mem_req = 1'b1; hz.i_mem_ack = 1'b1;
    #1;
    n_checks++; if (w_out !== V_NONE || o_state !== 2'b01) begin n_fail++; $display("FAIL mw_ack out=%b st=%b exp=%b st=01", w_out, o_state, V_NONE); end
    step();
    clr_inputs();
    #1;
    n_checks++; if (o_state !== 2'b00) begin n_fail++; $display("FAIL mw_release got=%b exp=00", o_state); end
    n_checks++; if (o_stall_cycles !== (PERF ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL mw_stall_ctr got=%0d exp=%0d", o_stall_cycles, PERF ? 3 : 0); end
    n_checks++; if (o_flush_events !== 32'd0) begin n_fail++; $display("FAIL mw_misp_ignored got=%0d exp=0", o_flush_events); end
    hz.i_mem_req = 1'b1;
    step();
    hz.i_mem_req = 1'b0;
    #1;
    n_checks++; if (o_state !== 2'b01) begin n_fail++; $display("FAIL mw_reenter got=%b exp=01", o_state); end
    i_reset = 1'b1;
    #1;
    n_checks++; if (o_state !== 2'b00 || o_mem_timeout !== 1'b0 || w_out !== V_NONE) begin n_fail++; $display("FAIL mw_async_rst st=%b tmo=%b out=%b exp st=00 tmo=0 out=0", o_state, o_mem_timeout, w_out); end
    step();
    i_reset = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    hz.i_mem_req = 1'b1;
    #1;
    n_checks++; if (w_out !== V_FREEZE || o_state !== 2'b00) begin n_fail++; $display("FAIL to_req out=%b st=%b exp=%b st=00", w_out, o_state, V_FREEZE); end
    step();
    hz.i_mem_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (w_out !== V_FREEZE || o_state !== 2'b01 || o_mem_timeout !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d out=%b st=%b tmo=%b exp=%b st=01 tmo=0", i, w_out, o_state, o_mem_timeout, V_FREEZE); end
      step();
    end
    #1;
    n_checks++; if (o_state !== 2'b10 || o_mem_timeout !== 1'b1) begin n_fail++; $display("FAIL to_enter st=%b tmo=%b exp st=10 tmo=1", o_state, o_mem_timeout); end
    n_checks++; if (w_out !== V_HALT) begin n_fail++; $display("FAIL to_halt out=%b exp=%b", w_out, V_HALT); end
    n_checks++; if (o_stall_cycles !== (PERF ? 32'd5 : 32'd0)) begin n_fail++; $display("FAIL to_stall_ctr got=%0d exp=%0d", o_stall_cycles, PERF ? 5 : 0); end
    hz.i_mem_req = 1'b1; hz.i_mem_ack = 1'b1;
    step();
    step();
    #1;
    n_checks++; if (o_state !== 2'b10 || o_mem_timeout !== 1'b1 || w_out !== V_HALT) begin n_fail++; $display("FAIL to_late_ack st=%b tmo=%b out=%b exp st=10 tmo=1 out=%b", o_state, o_mem_timeout, w_out, V_HALT); end
    i_reset = 1'b1;
    #1;
    n_checks++; if (o_state !== 2'b00 || o_mem_timeout !== 1'b0 || w_out !== V_NONE) begin n_fail++; $display("FAIL to_async_rst st=%b tmo=%b out=%b exp st=00 tmo=0 out=0", o_state, o_mem_timeout, w_out); end
    step();
    i_reset = 1'b0;
    clr_inputs();
    step();
  endtask

  task automatic test_ack_last();
    do_reset();
    hz.i_mem_req = 1'b1;
    step();
    hz.i_mem_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    hz.i_mem_ack = 1'b1;
    #1;
    n_checks++; if (w_out !== V_NONE || o_state !== 2'b01) begin n_fail++; $display("FAIL al_ack out=%b st=%b exp=%b st=01", w_out, o_state, V_NONE); end
    step();
    hz.i_mem_ack = 1'b0;
    #1;
    n_checks++; if (o_state !== 2'b00 || o_mem_timeout !== 1'b0) begin n_fail++; $display("FAIL al_run st=%b tmo=%b exp st=00 tmo=0", o_state, o_mem_timeout); end
    n_checks++; if (o_stall_cycles !== (PERF ? 32'd4 : 32'd0)) begin n_fail++; $display("FAIL al_stall_ctr got=%0d exp=%0d", o_stall_cycles, PERF ? 4 : 0); end
    step();
  endtask

  initial begin
    clr_inputs();
    i_reset = 1'b1;
    #1;
    test_reset();
    test_load_use();
    test_mispred();
    test_mem_wait();
    test_timeout();
    test_ack_last();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
